queue_arbiter: RTL and testbench
================================

Name: queue_arbiter

Overview:
- Round-robin arbiter that shares one downstream decoupled consumer among N upstream decoupled producers; typical consumer is a shared queue's enq side.
- Used wherever several pipeline sources feed one buffer, e.g. multiple writeback or issue paths into a common queue.
- Zero-latency combinational data path with a registered priority pointer.
- Once the output is offered and stalled, the grant is locked, so the output stays stable until it fires.

Parameters:
- Data, gpreg, payload type carried from producers to consumer
- N, 4, number of requesters; legal range 2..16
- IDX_WIDTH, $clog2(N), width of requester index (derived; not overridden)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  N  per-requester valid
- in_ready  output  N  per-requester ready; at most one bit set
- in_data  input  N x $bits(Data)  per-requester payload, element i belongs to requester i
- out_valid  output  1  valid toward consumer
- out_ready  input  1  consumer ready
- out_data  output  $bits(Data)  granted payload
- out_idx  output  IDX_WIDTH  index of granted requester, valid when out_valid=1

Behaviour:
- State: ptr (IDX_WIDTH, next-highest-priority requester), lock (1 bit), lock_idx (IDX_WIDTH).
- Reset: ptr=0, lock=0, lock_idx=0. In reset and the first cycle after, with all in_valid=0: out_valid=0, in_ready=0, out_idx=0.
- FREE state (lock=0):
  - grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N wrap).
  - out_valid = |in_valid.
  - out_idx = grant; out_data = in_data[grant].
  - in_ready[grant] = out_ready; all other in_ready bits = 0.
  - If no valid: out_idx = ptr; out_data is don't-care.
- LOCKED state (lock=1):
  - grant = lock_idx regardless of other requests.
  - out_valid = in_valid[lock_idx]; in_ready[lock_idx] = out_ready.
- Transitions:
  - FREE, out_valid && !out_ready -> LOCKED, lock_idx <= grant, ptr unchanged.
  - Fire (out_valid && out_ready) in either state -> FREE, ptr <= (grant+1) mod N. For N not a power of two, wrap explicitly at N-1 -> 0, not by truncation.
  - LOCKED with in_valid[lock_idx]=0 (protocol violation by producer) -> FREE, ptr unchanged.
- No combinational path from out_ready to out_valid, out_data or out_idx. The path out_ready -> in_ready is combinational by design.
- Latency: 0 cycles; payload passes combinationally in the fire cycle.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... One fire per cycle; no requester waits more than N-1 fires.
- A single requester valid alone fires every cycle while out_ready=1.
- Async reset mid-LOCKED: lock clears immediately; the pending beat is dropped from the arbiter's view. The producer keeps valid and re-arbitrates from ptr=0.

Optional Feature:
- Macro: QUEUE_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt, N x 32 bits.
  - Counter i increments by 1 on every fire with grant=i, wraps at 2^32, resets to 0 on rst.
  - Adds output stall_cnt, 32 bits: increments each cycle where out_valid && !out_ready; same wrap and reset rules.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, all in_valid=0 -> out_valid=0, in_ready=0000. Release reset, set in_valid=0100, in_data[2]=0x55, out_ready=1 -> out_valid=1, out_idx=2, out_data=0x55, in_ready=0100; next cycle ptr=3.
- N=4, in_valid=1111 held, out_ready=1 for 8 cycles -> out_idx sequence 0,1,2,3,0,1,2,3; exactly one in_ready bit per cycle.
- in_valid=0010 with out_ready=0 for 3 cycles, then raise in_valid[0] while still stalled -> out_idx stays 1 and out_data stays stable. Set out_ready=1 -> requester 1 fires, next grant is 0 (ptr=2 wraps to 0).
- N=3, in_valid=111 continuous, out_ready=1 -> grants 0,1,2,0. Confirm ptr wraps 2->0 and never reaches 3.
- Assert rst for 1 cycle while LOCKED on idx 3 -> lock=0, ptr=0. With in_valid=1001 after release, next grant is 0.
- With QUEUE_ARBITER_STATS_EN: run the 8-cycle round-robin test, then stall 5 cycles -> grant_cnt = {2,2,2,2}, stall_cnt = 5.

Source files
------------

// File: rtl/queue_arbiter.sv
// Round-robin arbiter sharing one decoupled consumer among N producers; grant locks while stalled.
// Optional per-requester grant and stall counters are built when QUEUE_ARBITER_STATS_EN is defined.
module queue_arbiter #(
  parameter type Data = logic [63:0],
  parameter int unsigned N = 4,
  localparam int unsigned IDX_WIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  Data  [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output Data                  out_data,
  output logic [IDX_WIDTH-1:0] out_idx
`ifdef QUEUE_ARBITER_STATS_EN
  ,
  output logic [N-1:0][31:0]   grant_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int unsigned SW = IDX_WIDTH + 1;
  localparam logic [SW-1:0] N_W = SW'(N);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

  lock_e                lock;
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] lock_idx;

  logic [IDX_WIDTH-1:0] rr_idx;
  logic [IDX_WIDTH-1:0] cand;
  logic [SW-1:0]        sum;
  logic                 found;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] ptr_nxt;
  logic                 fire;

  // Scan requesters starting at ptr, wrapping explicitly at N so non-power-of-two N never aliases.
  always_comb begin
    rr_idx = ptr;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[IDX_WIDTH-1:0];
      if (!found && in_valid[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Output mux; out_ready only reaches in_ready, never the offered beat.
  always_comb begin
    grant     = rr_idx;
    out_valid = |in_valid;
    if (lock == LOCKED) begin
      grant     = lock_idx;
      out_valid = in_valid[lock_idx];
    end
    out_idx  = grant;
    out_data = in_data[grant];
    fire     = out_valid & out_ready;
    in_ready = '0;
    if (fire) in_ready[grant] = 1'b1;
    ptr_nxt  = (grant == LAST_IDX) ? '0 : grant + IDX_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock     <= FREE;
      ptr      <= '0;
      lock_idx <= '0;
    end else if (fire) begin
      lock <= FREE;
      ptr  <= ptr_nxt;
    end else if (lock == FREE && out_valid) begin
      lock     <= LOCKED;
      lock_idx <= grant;
    end else if (lock == LOCKED && !in_valid[lock_idx]) begin
      // Producer withdrew a stalled beat: release without advancing priority.
      lock <= FREE;
    end
  end

`ifdef QUEUE_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire) grant_cnt[grant] <= grant_cnt[grant] + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: directed steps plus random traffic against a round-robin reference model.
module tb_queue_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      iv, ir;
  word_t [N-1:0]     id;
  logic              ordy, ov;
  word_t             od;
  logic [1:0]        oidx;

  logic [2:0]        iv3, ir3;
  word_t [2:0]       id3;
  logic              ordy3, ov3;
  word_t             od3;
  logic [1:0]        oidx3;

`ifdef QUEUE_ARBITER_STATS_EN
  logic [N-1:0][31:0] gc;
  logic [31:0]        sc;
  logic [2:0][31:0]   gc3;
  logic [31:0]        sc3;
`endif

  queue_arbiter #(.Data(word_t), .N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_idx(oidx)
`ifdef QUEUE_ARBITER_STATS_EN
    , .grant_cnt(gc), .stall_cnt(sc)
`endif
  );

  queue_arbiter #(.Data(word_t), .N(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_idx(oidx3)
`ifdef QUEUE_ARBITER_STATS_EN
    , .grant_cnt(gc3), .stall_cnt(sc3)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: priority pointer and the requester holding a stalled beat (-1 when none).
  int          m_ptr;
  int          m_held;
  int unsigned m_gcnt [N];
  int unsigned m_scnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_held = -1;
    m_scnt = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  task automatic model_eval(output int g, output logic v);
    logic found;
    found = 1'b0;
    if (m_held >= 0) begin
      g = m_held;
      v = iv[2'(m_held)];
    end else begin
      g = m_ptr;
      v = |iv;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && iv[2'(j)]) begin
          found = 1'b1;
          g = j;
        end
      end
    end
  endtask

  // Check the current cycle at the falling edge, then advance the model to the next rising edge.
  task automatic cycle();
    int         g;
    logic       v;
    logic [N-1:0] er;
    @(negedge clk);
    model_eval(g, v);
    er = '0;
    er[2'(g)] = v & ordy;
    check("out_valid", 64'(ov), 64'(v));
    check("out_idx", 64'(oidx), 64'(g));
    check("in_ready", 64'(ir), 64'(er));
    if (v) check("out_data", od, id[2'(g)]);
`ifdef QUEUE_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) check("grant_cnt", 64'(gc[i]), 64'(m_gcnt[i]));
    check("stall_cnt", 64'(sc), 64'(m_scnt));
`endif
    if (rst) begin
      model_reset();
    end else if (v && ordy) begin
      m_gcnt[2'(g)]++;
      m_ptr  = (g + 1) % N;
      m_held = -1;
    end else if (v) begin
      m_scnt++;
      m_held = g;
    end else if (m_held >= 0) begin
      m_held = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    word_t d1;
    rst   = 1'b1;
    iv    = '0;
    ordy  = 1'b1;
    iv3   = '0;
    ordy3 = 1'b0;
    for (int i = 0; i < N; i++) id[i] = word_t'(64'h1000 + i);
    for (int i = 0; i < 3; i++) id3[i] = word_t'(64'h3000 + i);
    model_reset();

    // Reset with nothing requested
    #1;
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_ready", 64'(ir), 64'd0);
    check("rst_idx", 64'(oidx), 64'd0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Lone requester 2 fires, priority moves to 3
    iv    = 4'b0100;
    id[2] = word_t'(64'h55);
    #1;
    check("single_idx", 64'(oidx), 64'd2);
    check("single_data", od, 64'h55);
    check("single_ready", 64'(ir), 64'b0100);
    cycle();
    iv = '0;
    #1;
    check("ptr_after_single", 64'(oidx), 64'd3);
    cycle();

    // Full round robin, then a 5-cycle stall
    do_reset();
    iv   = 4'b1111;
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_idx", 64'(oidx), 64'(k % N));
      check("rr_onehot", 64'($countones(ir)), 64'd1);
      cycle();
    end
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
`ifdef QUEUE_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) check("stats_grant", 64'(gc[i]), 64'd2);
    check("stats_stall", 64'(sc), 64'd5);
`endif

    // Stall locks requester 1 even after requester 0 arrives
    do_reset();
    iv   = 4'b0010;
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    d1 = id[1];
    iv = 4'b0011;
    #1;
    check("lock_idx", 64'(oidx), 64'd1);
    check("lock_data", od, d1);
    cycle();
    ordy = 1'b1;
    #1;
    check("lock_fire_ready", 64'(ir), 64'b0010);
    cycle();
    #1;
    check("after_lock_idx", 64'(oidx), 64'd0);
    cycle();

    // N=3 wraps 2 -> 0
    iv   = '0;
    do_reset();
    iv3   = 3'b111;
    ordy3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("n3_valid", 64'(ov3), 64'd1);
      check("n3_idx", 64'(oidx3), 64'(k % 3));
      check("n3_data", od3, id3[2'(k % 3)]);
      @(posedge clk);
      #1;
    end
    iv3   = '0;
    ordy3 = 1'b0;

    // Async reset while locked on 3
    do_reset();
    iv   = 4'b1000;
    ordy = 1'b0;
    cycle();
    cycle();
    #1;
    check("locked3_idx", 64'(oidx), 64'd3);
    rst = 1'b1;
    model_reset();
    iv  = 4'b1001;
    #1;
    check("midrst_idx", 64'(oidx), 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    check("postrst_idx", 64'(oidx), 64'd0);
    cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      if (($urandom % 64) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      if (($urandom % 2) == 0) iv = 4'($urandom);
      else iv = iv | 4'($urandom);
      ordy = (($urandom % 4) != 0);
      for (int i = 0; i < N; i++) id[i] = {$urandom, $urandom};
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
